s3_power_sequencer: RTL and testbench

- Ordered S3 entry/exit sequencer placed directly downstream of the power-management request logic.
- Converts a level sleep request and a wake event into a timed, strictly ordered sequence on the ALU/RAM power-control nets:
  - entry order: state save → clock gate → isolation → reset → power-down;
  - exit order: the exact reverse.
- Drives s3_state and the RAM write enable for save and restore.
- Handshakes with the external power switch through pwr_ack, with a timeout.

---
 rtl/s3_power_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_s3_power_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/s3_power_sequencer.sv
// S3 entry/exit sequencer: orders save, clock gate, isolation, reset and
// power-down on the way into S3, and unwinds them in reverse on wake.
module s3_power_sequencer #(
    parameter int unsigned STEP_DLY    = 4,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sleep_req,
    input  logic wake_evt,
    input  logic pwr_ack,
    output logic s3_state,
    output logic save_en,
    output logic clk_gate,
    output logic isolation,
    output logic reset_assert,
    output logic pg_down,
    output logic in_s3,
    output logic busy,
    output logic err
);

    localparam int unsigned MAX_DLY = (STEP_DLY > ACK_TIMEOUT) ? STEP_DLY : ACK_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(MAX_DLY + 1);

    typedef enum logic [3:0] {
        ST_ACTIVE,
        ST_SAVE,
        ST_GATE,
        ST_ISO,
        ST_RST,
        ST_PWROFF,
        ST_SLEEP,
        ST_PWRON,
        ST_UNRST,
        ST_UNISO,
        ST_UNGATE,
        ST_RESTORE
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_q, err_d;
    logic               s3_state_q, s3_state_d;
    logic               save_en_q, save_en_d;
    logic               clk_gate_q, clk_gate_d;
    logic               isolation_q, isolation_d;
    logic               reset_assert_q, reset_assert_d;
    logic               pg_down_q, pg_down_d;
    logic               in_s3_q, in_s3_d;
    logic               busy_q, busy_d;

    logic step_done;
    logic ack_done;

    assign step_done = (count_q == CNT_W'(STEP_DLY - 1));
    assign ack_done  = (count_q == CNT_W'(ACK_TIMEOUT - 1));

    // Next-state, sticky error and step counter; wake aborts entry into the mirror exit step.
    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        count_d = count_q;
        case (state_q)
            ST_ACTIVE: begin
                if (sleep_req && !wake_evt) begin
                    state_d = ST_SAVE;
                    err_d   = 1'b0;
                end
            end
            ST_SAVE: begin
                if (wake_evt)       state_d = ST_RESTORE;
                else if (step_done) state_d = ST_GATE;
            end
            ST_GATE: begin
                if (wake_evt)       state_d = ST_UNGATE;
                else if (step_done) state_d = ST_ISO;
            end
            ST_ISO: begin
                if (wake_evt)       state_d = ST_UNISO;
                else if (step_done) state_d = ST_RST;
            end
            ST_RST: begin
                if (wake_evt)       state_d = ST_UNRST;
                else if (step_done) state_d = ST_PWROFF;
            end
            ST_PWROFF: begin
                if (wake_evt) begin
                    state_d = ST_PWRON;
                end else if (pwr_ack) begin
                    state_d = ST_SLEEP;
                end else if (ack_done) begin
                    state_d = ST_PWRON;
                    err_d   = 1'b1;
                end
            end
            ST_SLEEP: begin
                if (wake_evt) state_d = ST_PWRON;
            end
            ST_PWRON: begin
                if (!pwr_ack) begin
                    state_d = ST_UNRST;
                end else if (ack_done) begin
                    state_d = ST_UNRST;
                    err_d   = 1'b1;
                end
            end
            ST_UNRST:   if (step_done) state_d = ST_UNISO;
            ST_UNISO:   if (step_done) state_d = ST_UNGATE;
            ST_UNGATE:  if (step_done) state_d = ST_RESTORE;
            ST_RESTORE: if (step_done) state_d = ST_ACTIVE;
            default:    state_d = ST_ACTIVE;
        endcase

        if (state_d != state_q) begin
            count_d = '0;
        end else if (state_q == ST_ACTIVE || state_q == ST_SLEEP) begin
            count_d = '0;
        end else begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // Output decode from the next state so outputs change on the entering edge.
    always_comb begin
        s3_state_d     = 1'b0;
        save_en_d      = 1'b0;
        clk_gate_d     = 1'b0;
        isolation_d    = 1'b1;
        reset_assert_d = 1'b0;
        pg_down_d      = 1'b0;
        in_s3_d        = 1'b0;
        busy_d         = 1'b1;
        case (state_d)
            ST_ACTIVE: busy_d = 1'b0;
            ST_SAVE: begin
                s3_state_d = 1'b1;
                save_en_d  = 1'b1;
            end
            ST_GATE, ST_UNISO: begin
                s3_state_d = 1'b1;
                clk_gate_d = 1'b1;
            end
            ST_ISO, ST_UNRST: begin
                s3_state_d  = 1'b1;
                clk_gate_d  = 1'b1;
                isolation_d = 1'b0;
            end
            ST_RST, ST_PWRON: begin
                s3_state_d     = 1'b1;
                clk_gate_d     = 1'b1;
                isolation_d    = 1'b0;
                reset_assert_d = 1'b1;
            end
            ST_PWROFF: begin
                s3_state_d     = 1'b1;
                clk_gate_d     = 1'b1;
                isolation_d    = 1'b0;
                reset_assert_d = 1'b1;
                pg_down_d      = 1'b1;
            end
            ST_SLEEP: begin
                s3_state_d     = 1'b1;
                clk_gate_d     = 1'b1;
                isolation_d    = 1'b0;
                reset_assert_d = 1'b1;
                pg_down_d      = 1'b1;
                in_s3_d        = 1'b1;
                busy_d         = 1'b0;
            end
            ST_UNGATE:  s3_state_d = 1'b1;
            ST_RESTORE: save_en_d  = 1'b1;
            default:    busy_d     = 1'b0;
        endcase
    end

    // State, counter and output registers; reset forces the safe powered-on state at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_ACTIVE;
            count_q        <= '0;
            err_q          <= 1'b0;
            s3_state_q     <= 1'b0;
            save_en_q      <= 1'b0;
            clk_gate_q     <= 1'b0;
            isolation_q    <= 1'b1;
            reset_assert_q <= 1'b0;
            pg_down_q      <= 1'b0;
            in_s3_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            err_q          <= err_d;
            s3_state_q     <= s3_state_d;
            save_en_q      <= save_en_d;
            clk_gate_q     <= clk_gate_d;
            isolation_q    <= isolation_d;
            reset_assert_q <= reset_assert_d;
            pg_down_q      <= pg_down_d;
            in_s3_q        <= in_s3_d;
            busy_q         <= busy_d;
        end
    end

    assign s3_state     = s3_state_q;
    assign save_en      = save_en_q;
    assign clk_gate     = clk_gate_q;
    assign isolation    = isolation_q;
    assign reset_assert = reset_assert_q;
    assign pg_down      = pg_down_q;
    assign in_s3        = in_s3_q;
    assign busy         = busy_q;
    assign err          = err_q;

endmodule

// File: tb/tb_s3_power_sequencer.sv
// Directed bench for s3_power_sequencer (STEP_DLY=4, ACK_TIMEOUT=16).
module tb_s3_power_sequencer;

    logic clk;
    logic reset;
    logic sleep_req;
    logic wake_evt;
    logic pwr_ack;
    logic s3_state, save_en, clk_gate, isolation, reset_assert, pg_down, in_s3, busy, err;

    int checks = 0;
    int errors = 0;

    // Output vector: {s3_state, save_en, clk_gate, isolation, reset_assert, pg_down, in_s3, busy, err}
    logic [8:0] obs;
    assign obs = {s3_state, save_en, clk_gate, isolation, reset_assert, pg_down, in_s3, busy, err};

    localparam logic [8:0] V_ACTIVE  = 9'b000100000;
    localparam logic [8:0] V_SAVE    = 9'b110100010;
    localparam logic [8:0] V_GATE    = 9'b101100010;
    localparam logic [8:0] V_ISO     = 9'b101000010;
    localparam logic [8:0] V_RST     = 9'b101010010;
    localparam logic [8:0] V_PWROFF  = 9'b101011010;
    localparam logic [8:0] V_SLEEP   = 9'b101011100;
    localparam logic [8:0] V_UNGATE  = 9'b100100010;
    localparam logic [8:0] V_RESTORE = 9'b010100010;
    localparam logic [8:0] E         = 9'b000000001;

    s3_power_sequencer #(
        .STEP_DLY    (4),
        .ACK_TIMEOUT (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sleep_req    (sleep_req),
        .wake_evt     (wake_evt),
        .pwr_ack      (pwr_ack),
        .s3_state     (s3_state),
        .save_en      (save_en),
        .clk_gate     (clk_gate),
        .isolation    (isolation),
        .reset_assert (reset_assert),
        .pg_down      (pg_down),
        .in_s3        (in_s3),
        .busy         (busy),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s @%0t: observed %b expected %b", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_check(input string tag, input logic [8:0] exp, input int n);
        for (int i = 0; i < n; i++) begin
            step();
            check(tag, exp);
        end
    endtask

    // Ordering invariants sampled every cycle on the inactive edge.
    always @(negedge clk) begin
        checks++;
        assert ((!pg_down || reset_assert) && (!reset_assert || !isolation) && (isolation || clk_gate)) else begin
            errors++;
            $error("FAIL invariant @%0t: observed %b expected ordered outputs", $time, obs);
        end
    end

    initial begin
        reset     = 1'b1;
        sleep_req = 1'b0;
        wake_evt  = 1'b0;
        pwr_ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", V_ACTIVE);
        reset = 1'b0;

        // Normal entry: sleep_req at cycle 0, pwr_ack 3 cycles after pg_down.
        sleep_req = 1'b1;
        run_check("entry_save", V_SAVE, 4);
        run_check("entry_gate", V_GATE, 4);
        run_check("entry_iso", V_ISO, 4);
        run_check("entry_rst", V_RST, 4);
        run_check("entry_pwroff", V_PWROFF, 4);
        pwr_ack = 1'b1;
        step();
        check("entry_sleep", V_SLEEP);
        sleep_req = 1'b0;
        run_check("sleep_hold", V_SLEEP, 3);

        // Normal exit: wake, pwr_ack falls 2 cycles later.
        wake_evt = 1'b1;
        step();
        check("exit_pwron", V_RST);
        wake_evt = 1'b0;
        step();
        check("exit_pwron", V_RST);
        pwr_ack = 1'b0;
        run_check("exit_unrst", V_ISO, 4);
        run_check("exit_uniso", V_GATE, 4);
        run_check("exit_ungate", V_UNGATE, 4);
        run_check("exit_restore", V_RESTORE, 4);
        run_check("exit_active", V_ACTIVE, 2);

        // Wake during the 2nd cycle of ISO aborts to UNISO.
        sleep_req = 1'b1;
        run_check("abort_save", V_SAVE, 4);
        run_check("abort_gate", V_GATE, 4);
        run_check("abort_iso", V_ISO, 2);
        wake_evt  = 1'b1;
        sleep_req = 1'b0;
        step();
        check("abort_uniso", V_GATE);
        wake_evt = 1'b0;
        run_check("abort_uniso", V_GATE, 3);
        run_check("abort_ungate", V_UNGATE, 4);
        run_check("abort_restore", V_RESTORE, 4);
        run_check("abort_active", V_ACTIVE, 2);

        // pwr_ack never rises: timeout in PWROFF sets err and unwinds.
        sleep_req = 1'b1;
        run_check("to_save", V_SAVE, 4);
        run_check("to_gate", V_GATE, 4);
        run_check("to_iso", V_ISO, 4);
        run_check("to_rst", V_RST, 4);
        sleep_req = 1'b0;
        run_check("to_pwroff", V_PWROFF, 16);
        run_check("to_pwron", V_RST | E, 1);
        run_check("to_unrst", V_ISO | E, 4);
        run_check("to_uniso", V_GATE | E, 4);
        run_check("to_ungate", V_UNGATE | E, 4);
        run_check("to_restore", V_RESTORE | E, 4);
        run_check("to_active_err", V_ACTIVE | E, 3);

        // Accepted entry clears err; wake in SAVE aborts to RESTORE; held sleep_req re-enters.
        sleep_req = 1'b1;
        step();
        check("err_clear_save", V_SAVE);
        wake_evt = 1'b1;
        step();
        check("save_abort_restore", V_RESTORE);
        wake_evt = 1'b0;
        run_check("save_abort_restore", V_RESTORE, 3);
        run_check("reentry_active", V_ACTIVE, 1);
        run_check("reentry_save", V_SAVE, 1);
        sleep_req = 1'b0;
        wake_evt  = 1'b1;
        step();
        check("reentry_abort", V_RESTORE);
        wake_evt = 1'b0;
        run_check("reentry_abort", V_RESTORE, 3);
        run_check("reentry_done", V_ACTIVE, 2);

        // Simultaneous sleep_req and wake_evt in ACTIVE: stay put.
        sleep_req = 1'b1;
        wake_evt  = 1'b1;
        run_check("both_active", V_ACTIVE, 3);
        wake_evt = 1'b0;

        // pwr_ack stuck high on wake: PWRON timeout after 16 cycles.
        run_check("pt_save", V_SAVE, 4);
        run_check("pt_gate", V_GATE, 4);
        run_check("pt_iso", V_ISO, 4);
        run_check("pt_rst", V_RST, 4);
        step();
        check("pt_pwroff", V_PWROFF);
        pwr_ack = 1'b1;
        step();
        check("pt_sleep", V_SLEEP);
        sleep_req = 1'b0;
        wake_evt  = 1'b1;
        step();
        check("pt_pwron", V_RST);
        wake_evt = 1'b0;
        run_check("pt_pwron", V_RST, 15);
        run_check("pt_unrst", V_ISO | E, 4);
        pwr_ack = 1'b0;
        run_check("pt_uniso", V_GATE | E, 4);
        run_check("pt_ungate", V_UNGATE | E, 4);
        run_check("pt_restore", V_RESTORE | E, 4);
        run_check("pt_active_err", V_ACTIVE | E, 2);

        // Asynchronous reset in the middle of RST.
        sleep_req = 1'b1;
        run_check("rr_save", V_SAVE, 4);
        run_check("rr_gate", V_GATE, 4);
        run_check("rr_iso", V_ISO, 4);
        run_check("rr_rst", V_RST, 2);
        reset = 1'b1;
        #1;
        check("async_reset", V_ACTIVE);
        sleep_req = 1'b0;
        run_check("in_reset", V_ACTIVE, 2);
        reset = 1'b0;
        run_check("after_reset", V_ACTIVE, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
